// File: rtl/gate_truth_sweeper.sv
// Clocked sweeper for an N-input combinational gate: walks every input vector,
// waits SETTLE cycles per vector, then checks the gate output against TRUTH.
module gate_truth_sweeper #(
    parameter int                  N      = 2,
    parameter int                  SETTLE = 4,
    parameter logic [(1<<N)-1:0]   TRUTH  = 4'b1000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic         gate_out,
    output logic [N-1:0] gate_in,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic [N-1:0] first_fail_vec,
    output logic         first_fail_valid
);

    localparam int            TW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [TW-1:0] T_LOAD = TW'(SETTLE - 1);
    localparam logic [N:0]    LAST   = (N+1)'((1 << N) - 1);

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

    // state is kept as a plain named signal so checkers can bind to it
    state_t        state, state_d;
    logic [N:0]    vec, vec_d, vec_next;
    logic [TW-1:0] timer, timer_d;
    logic [N-1:0]  gate_in_d, first_fail_vec_d;
    logic          busy_d, done_d, pass_d, first_fail_valid_d;
    logic [N:0]    err_count_d, err_inc;
    logic          mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            vec              <= '0;
            timer            <= '0;
            gate_in          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            state            <= state_d;
            vec              <= vec_d;
            timer            <= timer_d;
            gate_in          <= gate_in_d;
            busy             <= busy_d;
            done             <= done_d;
            pass             <= pass_d;
            err_count        <= err_count_d;
            first_fail_vec   <= first_fail_vec_d;
            first_fail_valid <= first_fail_valid_d;
        end
    end

    always_comb begin
        state_d            = state;
        vec_d              = vec;
        timer_d            = timer;
        gate_in_d          = gate_in;
        busy_d             = busy;
        done_d             = 1'b0;
        pass_d             = pass;
        err_count_d        = err_count;
        first_fail_vec_d   = first_fail_vec;
        first_fail_valid_d = first_fail_valid;
        mismatch           = (gate_out != TRUTH[vec[N-1:0]]);
        err_inc            = err_count + (N+1)'(mismatch);
        vec_next           = vec + 1'b1;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d            = WAIT;
                    vec_d              = '0;
                    timer_d            = T_LOAD;
                    gate_in_d          = '0;
                    busy_d             = 1'b1;
                    pass_d             = 1'b0;
                    err_count_d        = '0;
                    first_fail_vec_d   = '0;
                    first_fail_valid_d = 1'b0;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    gate_in_d = '0;
                end else if (timer == '0) begin
                    state_d = CHECK;
                end else begin
                    timer_d = timer - 1'b1;
                end
            end
            CHECK: begin
                if (abort) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    gate_in_d = '0;
                end else begin
                    err_count_d = err_inc;
                    if (mismatch && !first_fail_valid) begin
                        first_fail_vec_d   = vec[N-1:0];
                        first_fail_valid_d = 1'b1;
                    end
                    // done/pass are registered here so they are visible throughout DONE
                    if (vec == LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_inc == '0);
                    end else begin
                        state_d   = WAIT;
                        vec_d     = vec_next;
                        gate_in_d = vec_next[N-1:0];
                        timer_d   = T_LOAD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/gate_truth_sweeper.md
# gate_truth_sweeper

Self-checking sequencer for an N-input combinational gate (AND, OR, XOR, and so on). On `start` it drives every input combination 0 to 2^N−1 into the gate under test and holds each one for a programmable settle time. It then samples the gate output, compares it against a parameterised truth table, and reports the mismatch count, the first failing vector and pass/fail. It sits beside the basic-gate library as the clocked controller that replaces hand-timed `#5` input sweeps.

## Interface
Parameters:
- `N`, default 2: gate input count; 1 ≤ N ≤ 8.
- `SETTLE`, default 4: wait cycles per vector before sampling; ≥ 1.
- `TRUTH`, default 4'b1000 (AND): 2^N-bit expected output table; bit i is the expected output for input vector i.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a sweep; sampled only in IDLE.
- `abort` in 1: synchronous cancel; return to IDLE with no `done`.
- `gate_out` in 1: output of the gate under test.
- `gate_in` out N: input vector driven to the gate under test; registered.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse at sweep end.
- `pass` out 1: valid from `done`; 1 when `err_count` is 0.
- `err_count` out N+1: number of mismatching vectors.
- `first_fail_vec` out N: lowest vector that mismatched.
- `first_fail_valid` out 1: `first_fail_vec` holds a capture.

## Operation
- **Reset values:** all outputs 0, state IDLE, internal vector counter and settle timer 0. Reset asserted mid-sweep aborts immediately with the same values.
- **FSM states:** IDLE, WAIT, CHECK, DONE.
- **IDLE:**
  - On `start`=1: `gate_in`←0, vector counter←0, timer←SETTLE−1, `busy`←1, `err_count`←0, `first_fail_valid`←0, `first_fail_vec`←0, `pass`←0. Next state WAIT.
  - Otherwise all outputs hold, including `pass`, `err_count` and the first-fail capture from the last sweep.
- **WAIT:**
  - If timer is 0, go to CHECK.
  - Otherwise decrement the timer.
- **CHECK:** compare `gate_out` with `TRUTH[vec]`.
  - On mismatch: `err_count`+1. If `first_fail_valid`=0, capture `first_fail_vec`←vec and set `first_fail_valid`←1.
  - If vec = 2^N−1: next state DONE.
  - Otherwise: vec+1, `gate_in`←vec+1, timer←SETTLE−1, next state WAIT.
- **DONE:** for one cycle assert `done`=1, `busy`←0, and set `pass`=(`err_count`==0), counting the final CHECK result. Next state IDLE.
- **`start` handling:** ignored in every state other than IDLE, including the DONE cycle.
- **`abort`:** in WAIT or CHECK, go to IDLE with `busy`←0 and `gate_in`←0. No `done`, `pass` stays 0, and `err_count` keeps its partial value. `abort` has priority over the CHECK update in the same cycle. It has no effect in IDLE or DONE.
- **Width:** `err_count` is N+1 bits, so its maximum value 2^N cannot wrap. The vector counter is N+1 bits internally, so the terminal compare does not alias.

## Timing
- Let edge 0 be the edge that accepts `start`. After edge 0, `gate_in`=0 and `busy`=1.
- Each vector is held for SETTLE+1 cycles. `gate_out` is sampled on the edge SETTLE+1 after the vector was applied.
- Vector k is applied after edge k·(SETTLE+1) and checked at edge (k+1)·(SETTLE+1).
- `done` is high in the cycle after edge 2^N·(SETTLE+1); `busy` drops on that same edge.
- With the defaults: vectors change after edges 0, 5, 10 and 15; `done` is high after edge 20.
- Earliest next accepted `start` is the edge after the `done` cycle.
- `gate_out` must be stable within SETTLE cycles of a `gate_in` change. A gate model with up to SETTLE cycles of output latency is checked correctly.

## Test plan
- **Correct AND, defaults:** `start` pulse → `gate_in` steps 0, 1, 2, 3 with 5 cycles each; `done` after edge 20; `pass`=1; `err_count`=0; `first_fail_valid`=0.
- **Stuck-at-1 model** (`gate_out`=1) with AND table → `err_count`=3, `first_fail_vec`=0, `pass`=0.
- **Stuck-at-0 model** → `err_count`=1, `first_fail_vec`=3, `pass`=0.
- **XOR DUT** with TRUTH=4'b0110 and SETTLE=1 → `done` after edge 8, `pass`=1.
- **DUT output delayed 2 registers:**
  - SETTLE=4 → `pass`=1.
  - SETTLE=1 → `pass`=0 and `err_count`>0.
- **Control interruptions:**
  - `start` re-pulsed at edge 7 → ignored, `done` still after edge 20.
  - `abort` at edge 12 → IDLE, no `done`, `gate_in`=0.
  - `rst_n` low at edge 9 → all outputs 0 asynchronously; a fresh `start` then completes normally.
